// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO with launch FSM feeding a UART transmitter
//
// Buffers bytes written in bursts and releases them one at a time to the
// transmitter as a one-cycle start pulse with the data held stable until the
// transmitter reports done (or the done timeout expires).
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Rst       asynchronous active-low reset
//   i_Wr        write strobe, one byte per cycle
//   i_WrData    byte to enqueue
//   i_ClrOvf    clears sticky o_Overflow
//   i_TxReady   transmitter idle/ready level
//   i_TxDone    transmitter one-cycle done pulse
//   o_fTx       one-cycle start pulse to the transmitter
//   o_TxData    byte being sent, stable from o_fTx until back in IDLE
//   o_Full      FIFO holds 2^ADDR_W bytes
//   o_Empty     FIFO holds no bytes
//   o_Count     current occupancy
//   o_Overflow  sticky: a write was dropped
//   o_TxErr     one-cycle pulse: done timeout expired
//   o_Busy      launch FSM not idle
module uart_tx_queue #(
  parameter int ADDR_W = 4,
  parameter int TMO_W  = 20
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Wr,
  input  logic [7:0]        i_WrData,
  input  logic              i_ClrOvf,
  input  logic              i_TxReady,
  input  logic              i_TxDone,
  output logic              o_fTx,
  output logic [7:0]        o_TxData,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_TxErr,
  output logic              o_Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]    count_q, count_d;
  logic [7:0]         tx_data_q;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   tmo_inc;
  logic               full, empty, wr_acc, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never
  // rescues a write into a full FIFO.
  assign wr_acc  = i_Wr && !full;
  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && i_TxReady) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_inc;
        // Done takes priority over a coinciding timeout.
        if (i_TxDone) begin
          state_d = S_IDLE;
        end else if (&tmo_inc) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set wins over a simultaneous clear.
    ovf_d = ovf_q;
    if (i_Wr && full) begin
      ovf_d = 1'b1;
    end else if (i_ClrOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset; reset clears the pointers, which discards it.
  always_ff @(posedge i_Clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= i_WrData;
    end
  end

  // Start pulse decoded from state so an async reset drops it at once.
  assign o_fTx      = (state_q == S_SEND);
  assign o_TxData   = tx_data_q;
  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_TxErr    = err_q;
  assign o_Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Wr = 1'b0;
  logic [7:0] i_WrData = 8'h00;
  logic       i_ClrOvf = 1'b0;
  logic       i_TxReady = 1'b0;
  logic       i_TxDone = 1'b0;
  logic       o_fTx;
  logic [7:0] o_TxData;
  logic       o_Full;
  logic       o_Empty;
  logic [4:0] o_Count;
  logic       o_Overflow;
  logic       o_TxErr;
  logic       o_Busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_queue #(.ADDR_W(4), .TMO_W(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Wr(i_Wr), .i_WrData(i_WrData),
    .i_ClrOvf(i_ClrOvf), .i_TxReady(i_TxReady), .i_TxDone(i_TxDone),
    .o_fTx(o_fTx), .o_TxData(o_TxData), .o_Full(o_Full), .o_Empty(o_Empty),
    .o_Count(o_Count), .o_Overflow(o_Overflow), .o_TxErr(o_TxErr), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic       done;
    logic       e_ftx;
    logic [7:0] e_data;
    logic [4:0] e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send_and_check(input logic [7:0] exp, input int dly);
    bit seen = 0;
    bit bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_fTx) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("launch_seen", 32'(seen), 1);
    if (!seen) return;
    chk("launch_data", 32'(o_TxData), 32'(exp));
    for (int k = 0; k < dly; k++) begin
      step();
      if (o_fTx || !o_Busy || o_TxData !== exp) bad = 1;
    end
    chk("hold_until_done", 32'(bad), 0);
    i_TxDone = 1'b1;
    step();
    i_TxDone = 1'b0;
    chk("idle_after_done", 32'(o_Busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit bad;

    // wr, d, rdy, done | fTx, data, count, busy
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0};
    vecs[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 5'd1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 5'd1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 5'd0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 5'd0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 5'd0, 1'b0};

    // Reset state
    step();
    step();
    chk("rst_ftx", 32'(o_fTx), 0);
    chk("rst_data", 32'(o_TxData), 0);
    chk("rst_empty", 32'(o_Empty), 1);
    chk("rst_full", 32'(o_Full), 0);
    chk("rst_count", 32'(o_Count), 0);
    chk("rst_ovf", 32'(o_Overflow), 0);
    chk("rst_err", 32'(o_TxErr), 0);
    chk("rst_busy", 32'(o_Busy), 0);
    i_Rst = 1'b1;
    step();

    // Table: single byte launch, same-cycle pop/write, done ignored in SEND
    for (int i = 0; i < 12; i++) begin
      i_Wr = vecs[i].wr;
      i_WrData = vecs[i].d;
      i_TxReady = vecs[i].rdy;
      i_TxDone = vecs[i].done;
      step();
      chk($sformatf("vec%0d_ftx", i), 32'(o_fTx), 32'(vecs[i].e_ftx));
      chk($sformatf("vec%0d_data", i), 32'(o_TxData), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_count", i), 32'(o_Count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(o_Empty), 32'(vecs[i].e_cnt == 0));
      chk($sformatf("vec%0d_busy", i), 32'(o_Busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i), 32'(o_TxErr), 0);
    end
    i_Wr = 1'b0;
    i_TxDone = 1'b0;

    // Ordered burst 01..03, done 10 cycles after each launch
    i_TxReady = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i_Wr = 1'b1;
      i_WrData = 8'(i);
      step();
    end
    i_Wr = 1'b0;
    chk("burst_count", 32'(o_Count), 3);
    i_TxReady = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) send_and_check(8'(i), 10);
    chk("burst_empty", 32'(o_Empty), 1);

    // Fill to full, overflow, clear behaviour
    i_TxReady = 1'b0;
    for (int i = 0; i < 17; i++) begin
      i_Wr = 1'b1;
      i_WrData = 8'h10 + 8'(i);
      step();
      chk($sformatf("fill%0d_count", i), 32'(o_Count), (i < 16) ? i + 1 : 16);
      chk($sformatf("fill%0d_full", i), 32'(o_Full), 32'(i >= 15));
      chk($sformatf("fill%0d_ovf", i), 32'(o_Overflow), 32'(i == 16));
    end
    i_WrData = 8'h99;
    i_ClrOvf = 1'b1;
    step();
    chk("ovf_set_beats_clr", 32'(o_Overflow), 1);
    chk("ovf_full_count", 32'(o_Count), 16);
    i_Wr = 1'b0;
    step();
    i_ClrOvf = 1'b0;
    chk("ovf_cleared", 32'(o_Overflow), 0);
    i_TxReady = 1'b1;
    step();
    for (int i = 0; i < 16; i++) send_and_check(8'h10 + 8'(i), 2);
    chk("drain_empty", 32'(o_Empty), 1);

    // Done timeout: 15 cycles in WAIT -> o_TxErr
    for (int pass = 0; pass < 2; pass++) begin
      i_Wr = 1'b1;
      i_WrData = 8'h77 + 8'(pass);
      step();
      i_Wr = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (o_fTx) begin
          seen = 1;
          break;
        end
        step();
      end
      chk($sformatf("tmo%0d_launch", pass), 32'(seen), 1);
      step();
      bad = 0;
      for (int k = 1; k <= 14; k++) begin
        step();
        if (o_TxErr || !o_Busy) bad = 1;
      end
      chk($sformatf("tmo%0d_wait", pass), 32'(bad), 0);
      if (pass == 1) i_TxDone = 1'b1;
      step();
      i_TxDone = 1'b0;
      chk($sformatf("tmo%0d_err", pass), 32'(o_TxErr), (pass == 0) ? 1 : 0);
      chk($sformatf("tmo%0d_idle", pass), 32'(o_Busy), 0);
      step();
      chk($sformatf("tmo%0d_err_pulse", pass), 32'(o_TxErr), 0);
    end

    // Reset while in WAIT with 5 bytes queued
    i_TxReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_Wr = 1'b1;
      i_WrData = 8'hE0 + 8'(i);
      step();
    end
    i_Wr = 1'b0;
    i_TxReady = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_count", 32'(o_Count), 5);
    chk("pre_rst_busy", 32'(o_Busy), 1);
    i_Rst = 1'b0;
    #1;
    chk("rst_mid_ftx", 32'(o_fTx), 0);
    chk("rst_mid_count", 32'(o_Count), 0);
    chk("rst_mid_empty", 32'(o_Empty), 1);
    chk("rst_mid_busy", 32'(o_Busy), 0);
    step();
    i_Rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_fTx) bad = 1;
    end
    chk("no_ftx_after_rst", 32'(bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO plus launch FSM between byte producers (push-button encoders, loop-back of received bytes) and the UART transmitter.
- Buffers bytes written in bursts and releases them one at a time. Each release is a one-cycle start pulse with data held stable.
- Honours the transmitter's ready/done handshake.
- Sits directly upstream of the transmitter; its o_fTx/o_TxData drive the transmitter's start-pulse and data inputs.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W entries (16).
- TMO_W, 20, width of the done-timeout counter; timeout fires after 2^TMO_W - 1 cycles in WAIT.

Ports:
- i_Clk  in  1  system clock, all state on rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Wr  in  1  write strobe, one byte per cycle while high.
- i_WrData  in  8  byte to enqueue.
- i_ClrOvf  in  1  clears sticky o_Overflow.
- i_TxReady  in  1  transmitter idle/ready level.
- i_TxDone  in  1  transmitter one-cycle done pulse (stop bit finished).
- o_fTx  out  1  one-cycle start pulse to the transmitter.
- o_TxData  out  8  byte being sent; stable from the o_fTx cycle until return to IDLE.
- o_Full  out  1  count == 2^ADDR_W.
- o_Empty  out  1  count == 0.
- o_Count  out  ADDR_W+1  current occupancy.
- o_Overflow  out  1  sticky: a write was dropped.
- o_TxErr  out  1  one-cycle pulse: done timeout expired.
- o_Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, i_Rst=0):
  - rd/wr pointers = 0, count = 0.
  - o_fTx = 0, o_TxData = 8'h00, o_Overflow = 0, o_TxErr = 0, state = IDLE, timeout counter = 0.
  - Hence o_Empty = 1, o_Full = 0, o_Busy = 0.
  - FIFO contents are discarded. Reset mid-transfer drops o_fTx immediately and abandons the byte in flight.
- Write rules:
  - i_Wr=1 and o_Full=0: store i_WrData at wr pointer; pointer +1 mod 2^ADDR_W.
  - i_Wr=1 and o_Full=1: byte dropped; o_Overflow set next cycle. A write while full is rejected even if a pop occurs in the same cycle.
  - o_Overflow stays high until i_ClrOvf=1 or reset. If a set and i_ClrOvf occur in the same cycle, the set wins.
- Count update: +1 on accepted write only, -1 on pop only, unchanged when both occur. Pointers wrap naturally at 2^ADDR_W.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if o_Empty=0 and i_TxReady=1, pop the head into the o_TxData register, pulse o_fTx=1 for the next cycle, and go to SEND. Otherwise stay.
  - SEND: o_fTx=1 this cycle only. Go to WAIT unconditionally; clear the timeout counter. An i_TxDone seen in SEND is ignored.
  - WAIT: o_fTx=0; counter +1 per cycle.
    - i_TxDone=1: go to IDLE.
    - Counter reaches all-ones: go to IDLE, pulse o_TxErr one cycle; the byte counts as lost.
    - If i_TxDone and the timeout coincide, done wins (no o_TxErr).
- Latency: write into an empty FIFO at edge N gives o_Empty=0 after N. The IDLE pop fires at edge N+1; o_fTx is high during the cycle after edge N+1.
- Back-to-back: after i_TxDone, IDLE re-launches the next byte as soon as i_TxReady=1. The minimum spacing between o_fTx pulses is 2 cycles after done.
- Pop and write in the same cycle on a one-entry FIFO: the pop reads the old head. The new byte remains, count stays 1.
- o_TxData holds its last value in IDLE and changes only at a pop.

Test Plan:
- Reset then i_Wr pulse with 8'hA5, i_TxReady=1 -> o_fTx high exactly one cycle, 2 cycles after the write edge, o_TxData=8'hA5. Pulse i_TxDone -> o_Busy=0, o_Empty=1, o_Count=0.
- Write 8'h01..8'h03 on consecutive cycles; return i_TxDone 10 cycles after each o_fTx -> three o_fTx pulses carrying 01,02,03 in order; none launched before the prior done.
- i_TxReady=0, write 17 bytes 8'h10..8'h20 -> o_Full=1 at o_Count=16, 8'h20 dropped, o_Overflow=1. Write in the same cycle as i_ClrOvf -> o_Overflow stays 1. i_ClrOvf alone -> 0.
- Simultaneous write of 8'h55 and pop at count=1 (head 8'h44) -> o_TxData=8'h44, o_Count stays 1, next launch sends 8'h55.
- TMO_W=4, launch with no i_TxDone -> o_TxErr pulse exactly 15 cycles after entering WAIT, FSM back to IDLE. Same setup with i_TxDone on the 15th cycle -> no o_TxErr.
- i_Rst low for one cycle while in WAIT with 5 bytes queued -> o_fTx=0, o_Count=0, o_Empty=1, o_Busy=0 immediately, with no subsequent o_fTx.
